// File: rtl/zap_wb_pkg.sv
// Shared Wishbone definitions for the ZAP bus fabric: cycle-type encodings
// and the arbiter state type.
package zap_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_BURST   = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_GNT0 = 2'b01,
    ARB_GNT1 = 2'b10
  } arb_state_t;

endpackage

// File: rtl/zap_wb_rr_pick.sv
// Two-way request picker shared by the idle and release paths of the
// Wishbone arbiter; a tie goes to the master that was not granted last.
module zap_wb_rr_pick
  import zap_wb_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       pick,
  output logic       valid
);

  // Choose the winning master from the current request vector.
  always_comb begin
    valid = |req;
    pick  = 1'b0;
    if (req == 2'b11) begin
      if (ROUND_ROBIN != 0) begin
        pick = ~last_gnt;
      end else begin
        pick = 1'b0;
      end
    end else begin
      pick = req[1];
    end
  end

endmodule

// File: rtl/zap_wb_arbiter.sv
// Two-master to one-slave Wishbone B3 arbiter. The grant is held across a
// CTI burst until its end-of-burst beat (or BURST_MAX beats) is acked.
module zap_wb_arbiter
  import zap_wb_pkg::*;
#(
  parameter int ROUND_ROBIN = 1,
  parameter int BURST_MAX   = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_wb_cyc_m,
  input  logic [1:0]  i_wb_stb_m,
  input  logic [1:0]  i_wb_we_m,
  input  logic [7:0]  i_wb_sel_m,
  input  logic [5:0]  i_wb_cti_m,
  input  logic [63:0] i_wb_adr_m,
  input  logic [63:0] i_wb_dat_m,
  output logic [1:0]  o_wb_ack_m,
  output logic [31:0] o_wb_dat_m,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  output logic [2:0]  o_wb_cti,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_dat
);

  localparam int CTR_W = $clog2(BURST_MAX + 1);

  arb_state_t       state_r;
  logic             last_gnt_r;
  logic [CTR_W-1:0] beat_ctr_r;

  logic [1:0] req_s;
  logic       pick_s;
  logic       pick_valid_s;
  logic       gnt_s;
  logic       idx_s;
  logic       cur_cyc_s;
  logic       cur_stb_s;
  logic [2:0] cur_cti_s;
  logic       acked_s;
  logic       rel_s;

  assign req_s = i_wb_cyc_m & i_wb_stb_m;

  zap_wb_rr_pick #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_pick (
    .req      (req_s),
    .last_gnt (last_gnt_r),
    .pick     (pick_s),
    .valid    (pick_valid_s)
  );

  // Decode the current owner; reset masks the bus in the same cycle.
  always_comb begin
    gnt_s = 1'b0;
    idx_s = 1'b0;
    if (!i_reset) begin
      case (state_r)
        ARB_GNT0: begin
          gnt_s = 1'b1;
          idx_s = 1'b0;
        end
        ARB_GNT1: begin
          gnt_s = 1'b1;
          idx_s = 1'b1;
        end
        default: begin
          gnt_s = 1'b0;
          idx_s = 1'b0;
        end
      endcase
    end else begin
      gnt_s = 1'b0;
    end
  end

  assign cur_cyc_s = idx_s ? i_wb_cyc_m[1]   : i_wb_cyc_m[0];
  assign cur_stb_s = idx_s ? i_wb_stb_m[1]   : i_wb_stb_m[0];
  assign cur_cti_s = idx_s ? i_wb_cti_m[5:3] : i_wb_cti_m[2:0];
  assign acked_s   = gnt_s & cur_stb_s & i_wb_ack;

  // A dropped CYC also ends ownership so an idle owner cannot hog the bus.
  assign rel_s = gnt_s & ((acked_s & ((cur_cti_s == CTI_EOB) |
                          (beat_ctr_r == CTR_W'(BURST_MAX - 1)))) | ~cur_cyc_s);

  // Route the granted master to the slave and the slave response back.
  always_comb begin
    o_wb_cyc   = 1'b0;
    o_wb_stb   = 1'b0;
    o_wb_we    = 1'b0;
    o_wb_sel   = 4'h0;
    o_wb_cti   = 3'b000;
    o_wb_adr   = 32'h0;
    o_wb_dat   = 32'h0;
    o_wb_dat_m = 32'h0;
    o_wb_ack_m = 2'b00;
    if (gnt_s) begin
      o_wb_cyc   = cur_cyc_s;
      o_wb_stb   = cur_stb_s;
      o_wb_we    = idx_s ? i_wb_we_m[1]      : i_wb_we_m[0];
      o_wb_sel   = idx_s ? i_wb_sel_m[7:4]   : i_wb_sel_m[3:0];
      o_wb_cti   = cur_cti_s;
      o_wb_adr   = idx_s ? i_wb_adr_m[63:32] : i_wb_adr_m[31:0];
      o_wb_dat   = idx_s ? i_wb_dat_m[63:32] : i_wb_dat_m[31:0];
      o_wb_dat_m = i_wb_dat;
      o_wb_ack_m = idx_s ? {acked_s, 1'b0} : {1'b0, acked_s};
    end else begin
      o_wb_ack_m = 2'b00;
    end
  end

  // Grant state machine with burst lock and beat counting.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r    <= ARB_IDLE;
      last_gnt_r <= 1'b1;
      beat_ctr_r <= {CTR_W{1'b0}};
    end else begin
      case (state_r)
        ARB_IDLE: begin
          beat_ctr_r <= {CTR_W{1'b0}};
          if (pick_valid_s) begin
            state_r    <= pick_s ? ARB_GNT1 : ARB_GNT0;
            last_gnt_r <= pick_s;
          end
        end
        ARB_GNT0, ARB_GNT1: begin
          if (rel_s) begin
            beat_ctr_r <= {CTR_W{1'b0}};
            if (pick_valid_s) begin
              state_r    <= pick_s ? ARB_GNT1 : ARB_GNT0;
              last_gnt_r <= pick_s;
            end else begin
              state_r <= ARB_IDLE;
            end
          end else if (acked_s) begin
            beat_ctr_r <= beat_ctr_r + CTR_W'(1);
          end
        end
        default: begin
          state_r    <= ARB_IDLE;
          beat_ctr_r <= {CTR_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Directed bench for zap_wb_arbiter: three instances (round robin, fixed
// priority, short burst limit) share one set of master/slave stimulus.
module tb_zap_wb_arbiter;
  import zap_wb_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [1:0]  cyc, stb, we;
  logic [7:0]  sel;
  logic [5:0]  cti;
  logic [63:0] adr, wdat;
  logic        ack;
  logic [31:0] sdat;

  logic [1:0]  a_ack_m, b_ack_m, c_ack_m;
  logic [31:0] a_dat_m, b_dat_m, c_dat_m;
  logic        a_cyc, a_stb, a_we, b_cyc, b_stb, b_we, c_cyc, c_stb, c_we;
  logic [3:0]  a_sel, b_sel, c_sel;
  logic [2:0]  a_cti, b_cti, c_cti;
  logic [31:0] a_adr, b_adr, c_adr, a_dat, b_dat, c_dat;

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  zap_wb_arbiter #(.ROUND_ROBIN(1), .BURST_MAX(16)) u_a (
    .i_clk(i_clk), .i_reset(i_reset), .i_wb_cyc_m(cyc), .i_wb_stb_m(stb),
    .i_wb_we_m(we), .i_wb_sel_m(sel), .i_wb_cti_m(cti), .i_wb_adr_m(adr),
    .i_wb_dat_m(wdat), .o_wb_ack_m(a_ack_m), .o_wb_dat_m(a_dat_m),
    .o_wb_cyc(a_cyc), .o_wb_stb(a_stb), .o_wb_we(a_we), .o_wb_sel(a_sel),
    .o_wb_cti(a_cti), .o_wb_adr(a_adr), .o_wb_dat(a_dat),
    .i_wb_ack(ack), .i_wb_dat(sdat));

  zap_wb_arbiter #(.ROUND_ROBIN(0), .BURST_MAX(16)) u_b (
    .i_clk(i_clk), .i_reset(i_reset), .i_wb_cyc_m(cyc), .i_wb_stb_m(stb),
    .i_wb_we_m(we), .i_wb_sel_m(sel), .i_wb_cti_m(cti), .i_wb_adr_m(adr),
    .i_wb_dat_m(wdat), .o_wb_ack_m(b_ack_m), .o_wb_dat_m(b_dat_m),
    .o_wb_cyc(b_cyc), .o_wb_stb(b_stb), .o_wb_we(b_we), .o_wb_sel(b_sel),
    .o_wb_cti(b_cti), .o_wb_adr(b_adr), .o_wb_dat(b_dat),
    .i_wb_ack(ack), .i_wb_dat(sdat));

  zap_wb_arbiter #(.ROUND_ROBIN(1), .BURST_MAX(4)) u_c (
    .i_clk(i_clk), .i_reset(i_reset), .i_wb_cyc_m(cyc), .i_wb_stb_m(stb),
    .i_wb_we_m(we), .i_wb_sel_m(sel), .i_wb_cti_m(cti), .i_wb_adr_m(adr),
    .i_wb_dat_m(wdat), .o_wb_ack_m(c_ack_m), .o_wb_dat_m(c_dat_m),
    .o_wb_cyc(c_cyc), .o_wb_stb(c_stb), .o_wb_we(c_we), .o_wb_sel(c_sel),
    .o_wb_cti(c_cti), .o_wb_adr(c_adr), .o_wb_dat(c_dat),
    .i_wb_ack(ack), .i_wb_dat(sdat));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input int m, input logic c, input logic s, input logic w,
                       input logic [2:0] ct, input logic [31:0] a, input logic [31:0] d);
    cyc[m]          = c;
    stb[m]          = s;
    we[m]           = w;
    sel[m*4 +: 4]   = 4'hF;
    cti[m*3 +: 3]   = ct;
    adr[m*32 +: 32] = a;
    wdat[m*32 +: 32] = d;
  endtask

  task automatic idle_all();
    cyc  = 2'b00;
    stb  = 2'b00;
    we   = 2'b00;
    sel  = 8'h00;
    cti  = 6'h00;
    adr  = 64'h0;
    wdat = 64'h0;
    ack  = 1'b0;
    sdat = 32'h0;
  endtask

  task automatic do_reset();
    idle_all();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
  endtask

  initial begin
    idle_all();
    i_reset = 1'b1;
    // Reset state: requests and a slave ack present, everything stays quiet.
    drive(0, 1'b1, 1'b1, 1'b1, CTI_EOB, 32'h50, 32'h1);
    drive(1, 1'b1, 1'b1, 1'b1, CTI_EOB, 32'h60, 32'h2);
    ack  = 1'b1;
    sdat = 32'h1234;
    tick();
    tick();
    check_eq("rst_cyc", {63'h0, a_cyc}, 64'h0);
    check_eq("rst_stb", {63'h0, a_stb}, 64'h0);
    check_eq("rst_ack", {62'h0, a_ack_m}, 64'h0);
    check_eq("rst_adr", {32'h0, a_adr}, 64'h0);
    check_eq("rst_datm", {32'h0, a_dat_m}, 64'h0);

    // 1: single M0 read with one bubble.
    do_reset();
    drive(0, 1'b1, 1'b1, 1'b0, CTI_EOB, 32'h100, 32'h0);
    settle();
    check_eq("t1_bubble", {63'h0, a_stb}, 64'h0);
    tick();
    ack  = 1'b1;
    sdat = 32'hDEADBEEF;
    settle();
    check_eq("t1_stb", {63'h0, a_stb}, 64'h1);
    check_eq("t1_adr", {32'h0, a_adr}, 64'h100);
    check_eq("t1_ack", {62'h0, a_ack_m}, 64'h1);
    check_eq("t1_dat", {32'h0, a_dat_m}, 64'hDEADBEEF);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, CTI_CLASSIC, 32'h0, 32'h0);
    settle();
    check_eq("t1_drop_cyc", {63'h0, a_cyc}, 64'h0);
    check_eq("t1_drop_ack", {62'h0, a_ack_m}, 64'h0);
    tick();
    check_eq("t1_idle_stb", {63'h0, a_stb}, 64'h0);
    check_eq("t1_idle_ack", {62'h0, a_ack_m}, 64'h0);

    // 2: M0 4-beat burst, M1 arrives at beat 2 and waits for the EOB ack.
    do_reset();
    drive(0, 1'b1, 1'b1, 1'b0, CTI_BURST, 32'h200, 32'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, 1'b1, 1'b0, (k == 3) ? CTI_EOB : CTI_BURST, 32'h200 + 32'(4 * k), 32'h0);
      if (k == 1) drive(1, 1'b1, 1'b1, 1'b0, CTI_EOB, 32'h900, 32'h0);
      ack  = 1'b1;
      sdat = 32'(k);
      settle();
      check_eq($sformatf("t2_adr%0d", k), {32'h0, a_adr}, {32'h0, 32'h200 + 32'(4 * k)});
      check_eq($sformatf("t2_ack%0d", k), {62'h0, a_ack_m}, 64'h1);
      tick();
    end
    drive(0, 1'b0, 1'b0, 1'b0, CTI_CLASSIC, 32'h0, 32'h0);
    ack = 1'b0;
    settle();
    check_eq("t2_m1_adr", {32'h0, a_adr}, 64'h900);
    check_eq("t2_m1_stb", {63'h0, a_stb}, 64'h1);
    ack = 1'b1;
    settle();
    check_eq("t2_m1_ack", {62'h0, a_ack_m}, 64'h2);
    tick();

    // 3: both masters issue back-to-back single writes.
    do_reset();
    drive(0, 1'b1, 1'b1, 1'b1, CTI_EOB, 32'h300, 32'h11);
    drive(1, 1'b1, 1'b1, 1'b1, CTI_EOB, 32'h400, 32'h22);
    ack = 1'b1;
    settle();
    check_eq("t3_idle_rr", {62'h0, a_ack_m}, 64'h0);
    check_eq("t3_idle_fx", {62'h0, b_ack_m}, 64'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      settle();
      check_eq($sformatf("t3_rr_ack%0d", k), {62'h0, a_ack_m}, (k % 2 == 0) ? 64'h1 : 64'h2);
      check_eq($sformatf("t3_rr_dat%0d", k), {32'h0, a_dat}, (k % 2 == 0) ? 64'h11 : 64'h22);
      check_eq($sformatf("t3_fx_ack%0d", k), {62'h0, b_ack_m}, 64'h1);
      check_eq($sformatf("t3_fx_adr%0d", k), {32'h0, b_adr}, 64'h300);
      tick();
    end

    // 4: M1 write burst with a 3-cycle STB gap while M0 waits.
    do_reset();
    drive(1, 1'b1, 1'b1, 1'b1, CTI_BURST, 32'h500, 32'hAAAA);
    tick();
    drive(0, 1'b1, 1'b1, 1'b0, CTI_EOB, 32'h600, 32'h0);
    ack = 1'b1;
    settle();
    check_eq("t4_b1_ack", {62'h0, a_ack_m}, 64'h2);
    check_eq("t4_b1_adr", {32'h0, a_adr}, 64'h500);
    tick();
    for (int g = 0; g < 3; g++) begin
      drive(1, 1'b1, 1'b0, 1'b1, CTI_BURST, 32'h504, 32'hBBBB);
      settle();
      check_eq($sformatf("t4_gap_stb%0d", g), {63'h0, a_stb}, 64'h0);
      check_eq($sformatf("t4_gap_ack%0d", g), {62'h0, a_ack_m}, 64'h0);
      check_eq($sformatf("t4_gap_we%0d", g), {63'h0, a_we}, 64'h1);
      tick();
    end
    drive(1, 1'b1, 1'b1, 1'b1, CTI_EOB, 32'h504, 32'hBBBB);
    settle();
    check_eq("t4_b2_adr", {32'h0, a_adr}, 64'h504);
    check_eq("t4_b2_ack", {62'h0, a_ack_m}, 64'h2);
    tick();
    drive(1, 1'b0, 1'b0, 1'b0, CTI_CLASSIC, 32'h0, 32'h0);
    settle();
    check_eq("t4_m0_adr", {32'h0, a_adr}, 64'h600);
    check_eq("t4_m0_ack", {62'h0, a_ack_m}, 64'h1);
    tick();

    // 5: runaway M0 burst; the BURST_MAX=4 instance releases to M1.
    do_reset();
    drive(0, 1'b1, 1'b1, 1'b0, CTI_BURST, 32'h700, 32'h0);
    drive(1, 1'b1, 1'b1, 1'b0, CTI_EOB, 32'h800, 32'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, 1'b1, 1'b0, CTI_BURST, 32'h700 + 32'(4 * k), 32'h0);
      ack = 1'b1;
      settle();
      check_eq($sformatf("t5_adr%0d", k), {32'h0, c_adr}, {32'h0, 32'h700 + 32'(4 * k)});
      check_eq($sformatf("t5_ack%0d", k), {62'h0, c_ack_m}, 64'h1);
      tick();
    end
    drive(0, 1'b1, 1'b1, 1'b0, CTI_BURST, 32'h710, 32'h0);
    settle();
    check_eq("t5_rel_adr", {32'h0, c_adr}, 64'h800);
    check_eq("t5_rel_ack", {62'h0, c_ack_m}, 64'h2);
    check_eq("t5_long_adr", {32'h0, a_adr}, 64'h710);
    check_eq("t5_long_ack", {62'h0, a_ack_m}, 64'h1);
    tick();

    // 6: reset after beat 2 of an 8-beat burst, then a fresh tie.
    do_reset();
    drive(0, 1'b1, 1'b1, 1'b0, CTI_BURST, 32'hA00, 32'h0);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(0, 1'b1, 1'b1, 1'b0, CTI_BURST, 32'hA00 + 32'(4 * k), 32'h0);
      ack = 1'b1;
      settle();
      check_eq($sformatf("t6_ack%0d", k), {62'h0, a_ack_m}, 64'h1);
      tick();
    end
    drive(0, 1'b1, 1'b1, 1'b0, CTI_BURST, 32'hA08, 32'h0);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    drive(0, 1'b1, 1'b1, 1'b0, CTI_EOB, 32'hA00, 32'h0);
    drive(1, 1'b1, 1'b1, 1'b0, CTI_EOB, 32'hB00, 32'h0);
    ack = 1'b1;
    settle();
    check_eq("t6_post_cyc", {63'h0, a_cyc}, 64'h0);
    check_eq("t6_post_stb", {63'h0, a_stb}, 64'h0);
    check_eq("t6_post_ack", {62'h0, a_ack_m}, 64'h0);
    check_eq("t6_post_adr", {32'h0, a_adr}, 64'h0);
    tick();
    check_eq("t6_tie_adr", {32'h0, a_adr}, 64'hA00);
    check_eq("t6_tie_ack", {62'h0, a_ack_m}, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
